// File: rtl/wb_sram_arbiter.sv
// Round-robin arbiter sequencing Wishbone and core accesses onto one single-port SRAM.
// Each access is IDLE -> ISSUE (m_en) -> RESP (ack + read data), i.e. one access per 3 cycles.
module wb_sram_arbiter #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_F000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              core_en,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [3:0]        c_be,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [31:0]       c_wdata,
    output logic              c_ack,
    output logic [31:0]       c_rdata,
    output logic              m_en,
    output logic [3:0]        m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic OWN_W = 1'b0;
    localparam logic OWN_C = 1'b1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_owner;
    logic              w_owner_nxt;
    logic              r_rr_last;
    logic              w_rr_last_nxt;
    logic              w_wb_hit;
    logic              w_c_hit;
    logic [ADDR_W-1:0] w_wb_word;

    assign w_wb_hit  = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
    assign w_c_hit   = c_req & core_en;
    assign w_wb_word = wbs_adr_i[ADDR_W+1:2];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= IDLE;
            r_owner   <= OWN_W;
            r_rr_last <= OWN_C;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_rr_last <= w_rr_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_rr_last_nxt = r_rr_last;
        wbs_ack_o     = 1'b0;
        wbs_dat_o     = 32'd0;
        c_ack         = 1'b0;
        c_rdata       = 32'd0;
        m_en          = 1'b0;
        m_we          = 4'd0;
        m_addr        = '0;
        m_wdata       = 32'd0;

        // Reset gates every output in the same cycle, so an in-flight access never acks.
        if (!wb_rst_i) begin
            case (r_state)
                IDLE: begin
                    if (w_wb_hit && w_c_hit) begin
                        w_owner_nxt = ~r_rr_last;
                        w_state_nxt = ISSUE;
                    end else if (w_wb_hit) begin
                        w_owner_nxt = OWN_W;
                        w_state_nxt = ISSUE;
                    end else if (w_c_hit) begin
                        w_owner_nxt = OWN_C;
                        w_state_nxt = ISSUE;
                    end
                end
                ISSUE: begin
                    m_en          = 1'b1;
                    w_rr_last_nxt = r_owner;
                    w_state_nxt   = RESP;
                    if (r_owner == OWN_C) begin
                        m_addr  = c_addr;
                        m_wdata = c_wdata;
                        m_we    = c_we ? c_be : 4'd0;
                    end else begin
                        m_addr  = w_wb_word;
                        m_wdata = wbs_dat_i;
                        m_we    = wbs_we_i ? wbs_sel_i : 4'd0;
                    end
                end
                RESP: begin
                    w_state_nxt = IDLE;
                    if (r_owner == OWN_C) begin
                        c_ack   = 1'b1;
                        c_rdata = m_rdata;
                    end else if (wbs_cyc_i) begin
                        // A dropped cycle still completed its SRAM access; only the ack is withheld.
                        wbs_ack_o = 1'b1;
                        wbs_dat_o = m_rdata;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Bench for wb_sram_arbiter: behavioural SRAM, byte-merging memory model and round-robin expectation.
// Inputs change and outputs are sampled on the falling edge.
module tb_wb_sram_arbiter;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              wb_rst_i;
    logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_adr_i, wbs_dat_i;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;
    logic              core_en, c_req, c_we;
    logic [3:0]        c_be;
    logic [ADDR_W-1:0] c_addr;
    logic [31:0]       c_wdata;
    logic              c_ack;
    logic [31:0]       c_rdata;
    logic              m_en;
    logic [3:0]        m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;

    logic              mem_clr;
    logic [31:0]       mem     [1024];
    logic [31:0]       ref_mem [1024];
    bit                last_c;
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    wb_sram_arbiter #(.ADDR_W(ADDR_W)) dut (
        .wb_clk_i (clk),       .wb_rst_i (wb_rst_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .core_en  (core_en),   .c_req    (c_req),     .c_we     (c_we),
        .c_be     (c_be),      .c_addr   (c_addr),    .c_wdata  (c_wdata),
        .c_ack    (c_ack),     .c_rdata  (c_rdata),
        .m_en     (m_en),      .m_we     (m_we),      .m_addr   (m_addr),
        .m_wdata  (m_wdata),   .m_rdata  (m_rdata)
    );

    // Synchronous SRAM: read data appears the cycle after m_en.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
        end else if (m_en) begin
            m_rdata <= mem[m_addr];
            for (int b = 0; b < 4; b++)
                if (m_we[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_men"},  32'(m_en),      32'd0);
        chk({tag, "_wack"}, 32'(wbs_ack_o), 32'd0);
        chk({tag, "_cack"}, 32'(c_ack),     32'd0);
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b1;
        repeat (2) @(negedge clk);
        chk_quiet("rst");
        wb_rst_i = 1'b0;
        last_c = 1'b1;
    endtask

    // Entered and left on the falling edge of an IDLE cycle.
    task automatic do_access(input bit wv, input bit cv,
                             input bit wwe, input logic [ADDR_W-1:0] wa, input logic [3:0] wsel,
                             input logic [31:0] wd,
                             input bit cwe, input logic [ADDR_W-1:0] ca, input logic [3:0] cbe,
                             input logic [31:0] cd);
        bit                order[2];
        int                n;
        bit                r, rwe;
        logic [ADDR_W-1:0] ea;
        logic [3:0]        ebe;
        logic [31:0]       ed;
        if (wv && cv) begin
            order[0] = !last_c; order[1] = last_c; n = 2;
        end else begin
            order[0] = cv; order[1] = 1'b0; n = 1;
        end
        if (wv) begin
            wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = wwe; wbs_sel_i = wsel;
            wbs_adr_i = 32'h3000_0000 | (32'(wa) << 2) | 32'($urandom_range(0, 3));
            wbs_dat_i = wd;
        end
        if (cv) begin
            c_req = 1'b1; c_we = cwe; c_be = cbe; c_addr = ca; c_wdata = cd;
        end
        for (int k = 0; k < n; k++) begin
            r   = order[k];
            rwe = r ? cwe : wwe;
            ea  = r ? ca : wa;
            ebe = r ? cbe : wsel;
            ed  = r ? cd : wd;
            @(negedge clk);
            chk("iss_men",   32'(m_en),    32'd1);
            chk("iss_addr",  32'(m_addr),  32'(ea));
            chk("iss_we",    32'(m_we),    rwe ? 32'(ebe) : 32'd0);
            chk("iss_wdata", m_wdata,      ed);
            chk("iss_wack",  32'(wbs_ack_o), 32'd0);
            chk("iss_cack",  32'(c_ack),   32'd0);
            @(negedge clk);
            chk("resp_men",  32'(m_en),      32'd0);
            chk("resp_wack", 32'(wbs_ack_o), 32'(!r));
            chk("resp_cack", 32'(c_ack),     32'(r));
            if (!rwe) chk(r ? "c_rdata" : "wb_rdata", r ? c_rdata : wbs_dat_o, ref_mem[ea]);
            chk("nonowner_dat", r ? wbs_dat_o : c_rdata, 32'd0);
            if (rwe) ref_mem[ea] = merge(ref_mem[ea], ed, ebe);
            last_c = r;
            if (r) c_req = 1'b0;
            else begin wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; end
            @(negedge clk);
            chk_quiet("idle");
        end
    endtask

    initial begin
        wb_rst_i = 1'b1; mem_clr = 1'b1;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
        core_en = 1'b1; c_req = 0; c_we = 0; c_be = 0; c_addr = 0; c_wdata = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
        repeat (3) @(negedge clk);
        mem_clr = 1'b0;
        chk_quiet("reset");
        chk("reset_we",    32'(m_we),   32'd0);
        chk("reset_addr",  32'(m_addr), 32'd0);
        chk("reset_wdata", m_wdata,     32'd0);
        chk("reset_wdat",  wbs_dat_o,   32'd0);
        chk("reset_crd",   c_rdata,     32'd0);
        wb_rst_i = 1'b0;
        last_c = 1'b1;

        // Wishbone write then read-back of word 4.
        do_access(1, 0, 1, 10'd4, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0);
        do_access(1, 0, 0, 10'd4, 4'hF, 32'h0, 0, 0, 0, 0);

        // Out-of-window access is ignored.
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h3000_1010;
        repeat (4) begin
            @(negedge clk);
            chk_quiet("miss");
        end
        wbs_cyc_i = 0; wbs_stb_i = 0;

        // Ties: after reset W wins, after a W-only access C wins.
        do_reset();
        do_access(1, 1, 1, 10'd7, 4'hF, 32'h01020304, 1, 10'd8, 4'hF, 32'h0A0B0C0D);
        do_access(1, 0, 0, 10'd8, 4'hF, 32'h0, 0, 0, 0, 0);
        do_access(1, 1, 0, 10'd7, 4'hF, 32'h0, 0, 10'd8, 4'hF, 32'h0);

        // core_en low masks a continuously requesting core.
        core_en = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_be = 4'hF; c_addr = 10'd7; c_wdata = 32'h0;
        repeat (7)
            do_access(1, 0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
                      4'($urandom_range(0, 15)), $urandom(), 0, 0, 0, 0);
        core_en = 1'b1;
        do_access(0, 1, 0, 0, 0, 0, 0, 10'd7, 4'hF, 32'h0);

        // Byte write into the top word, then read it back.
        do_access(1, 0, 1, 10'h3FF, 4'hF, 32'h11223344, 0, 0, 0, 0);
        do_access(0, 1, 0, 0, 0, 0, 1, 10'h3FF, 4'b0100, 32'h00AB0000);
        do_access(0, 1, 0, 0, 0, 0, 0, 10'h3FF, 4'hF, 32'h0);

        // Reset during RESP of a core read.
        c_req = 1'b1; c_we = 1'b0; c_be = 4'hF; c_addr = 10'd4;
        @(negedge clk);
        chk("rstmid_iss_men", 32'(m_en), 32'd1);
        @(posedge clk);
        #1 wb_rst_i = 1'b1;
        @(negedge clk);
        chk("rstmid_cack", 32'(c_ack), 32'd0);
        chk("rstmid_men",  32'(m_en),  32'd0);
        chk("rstmid_crd",  c_rdata,    32'd0);
        c_req = 1'b0;
        @(negedge clk);
        chk_quiet("rstmid_after");
        wb_rst_i = 1'b0;
        last_c = 1'b1;
        do_access(1, 0, 0, 10'd4, 4'hF, 32'h0, 0, 0, 0, 0);

        // Wishbone abort after issue: SRAM write lands, ack is withheld.
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h3000_0014; wbs_dat_i = 32'hCAFEF00D;
        @(negedge clk);
        chk("abort_iss_men", 32'(m_en), 32'd1);
        wbs_cyc_i = 0;
        @(negedge clk);
        chk("abort_ack", 32'(wbs_ack_o), 32'd0);
        wbs_stb_i = 0;
        ref_mem[5] = 32'hCAFEF00D;
        last_c = 1'b0;
        @(negedge clk);
        chk_quiet("abort_idle");
        do_access(1, 0, 0, 10'd5, 4'hF, 32'h0, 0, 0, 0, 0);

        // Randomised mix of single and contending accesses.
        for (int it = 0; it < 40; it++) begin
            bit wv, cv;
            wv = 1'($urandom_range(0, 1));
            cv = wv ? 1'($urandom_range(0, 1)) : 1'b1;
            do_access(wv, cv,
                      1'($urandom_range(0, 1)), 10'($urandom_range(0, 63)),
                      4'($urandom_range(0, 15)), $urandom(),
                      1'($urandom_range(0, 1)), 10'($urandom_range(0, 63)),
                      4'($urandom_range(0, 15)), $urandom());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
